// File: rtl/mux3to1_32bit.sv
// ============================================================================
// Module      : mux3to1_32bit
// Description : Three-input word selector for the RISC-V datapath. Produces a
//               purely combinational result r chosen by a 2-bit select, plus
//               an enable-gated registered copy of the result and select code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux3to1_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_q,
    output logic [1:0]       sel_q
);

    localparam logic [1:0] c_SEL_A  = 2'b00;
    localparam logic [1:0] c_SEL_B  = 2'b01;
    localparam logic [1:0] c_SEL_C  = 2'b10;
    localparam logic [1:0] c_SEL_C2 = 2'b11;

    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] w_data_d;
    logic [1:0]       r_sel_q;
    logic [1:0]       w_sel_d;

    // Combinational select; code 11 aliases source c. An unknown select
    // matches no item and drives X so it cannot hide behind a default source.
    always_comb begin
        w_r = 'x;
        case (sel)
            c_SEL_A:           w_r = a;
            c_SEL_B:           w_r = b;
            c_SEL_C, c_SEL_C2: w_r = c;
            default:           w_r = 'x;
        endcase
    end

    assign r = w_r;

    // Next-state for the registered copy: load on enable, otherwise hold.
    always_comb begin
        w_data_d = r_data_q;
        w_sel_d  = r_sel_q;
        if (en_i) begin
            w_data_d = w_r;
            w_sel_d  = sel;
        end
    end

    // Registered copy with synchronous reset taking priority over enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data_q <= '0;
            r_sel_q  <= c_SEL_A;
        end else begin
            r_data_q <= w_data_d;
            r_sel_q  <= w_sel_d;
        end
    end

    assign r_q   = r_data_q;
    assign sel_q = r_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux3to1_32bit.sv
// ============================================================================
// Module      : tb_mux3to1_32bit
// Description : Self-checking bench for mux3to1_32bit with a behavioural
//               reference model and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux3to1_32bit;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         clk_run = 1'b0;
    logic         rst_i = 1'b0;
    logic         en_i  = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic [1:0]   sel = 2'b00;
    logic [W-1:0] r;
    logic [W-1:0] r_q;
    logic [1:0]   sel_q;

    // Reference state of the registered outputs
    logic [W-1:0] m_rq;
    logic [1:0]   m_selq;

    int n_checks = 0;
    int n_pass   = 0;

    mux3to1_32bit #(.WIDTH(W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .a     (a),
        .b     (b),
        .c     (c),
        .sel   (sel),
        .r     (r),
        .r_q   (r_q),
        .sel_q (sel_q)
    );

    // Clock only toggles while clk_run is set, so combinational tests run clockless
    initial begin
        forever begin
            #5;
            if (clk_run) clk_i = ~clk_i;
        end
    end

    // Sources indexed by select; codes beyond 2 saturate to source c
    function automatic logic [W-1:0] ref_mux(input logic [W-1:0] sa, input logic [W-1:0] sb,
                                            input logic [W-1:0] sc, input logic [1:0] s);
        logic [W-1:0] src [3];
        int idx;
        src[0] = sa;
        src[1] = sb;
        src[2] = sc;
        idx = int'(s);
        if (idx > 2) idx = 2;
        return src[idx];
    endfunction

    // Advance the model with the inputs present at the edge, then step past it
    task automatic tick();
        if (rst_i) begin
            m_rq   = '0;
            m_selq = 2'b00;
        end else if (en_i) begin
            m_rq   = ref_mux(a, b, c, sel);
            m_selq = sel;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_comb_sweep();
        logic [W-1:0] exp_r [4];
        exp_r[0] = 32'hAAAA_AAAA;
        exp_r[1] = 32'hBBBB_BBBB;
        exp_r[2] = 32'hCCCC_CCCC;
        exp_r[3] = 32'hCCCC_CCCC;
        a = 32'hAAAA_AAAA;
        b = 32'hBBBB_BBBB;
        c = 32'hCCCC_CCCC;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #10;
            n_checks++;
            if (r !== exp_r[i])
                $display("FAIL comb_sweep sel=%0d r=%h expected %h", i, r, exp_r[i]);
            else n_pass++;
        end
    endtask

    task automatic test_data_indep();
        sel = 2'b01;
        a   = 32'h1234_5678;
        c   = 32'hFFFF_FFFF;
        #10;
        n_checks++;
        if (r !== 32'hBBBB_BBBB)
            $display("FAIL data_indep_hold r=%h expected %h", r, 32'hBBBB_BBBB);
        else n_pass++;
        b = 32'h0000_0001;
        #1;
        n_checks++;
        if (r !== 32'h0000_0001)
            $display("FAIL data_indep_follow r=%h expected %h", r, 32'h0000_0001);
        else n_pass++;
    endtask

    task automatic test_reset();
        a = 32'hAAAA_AAAA;
        b = 32'hBBBB_BBBB;
        c = 32'hCCCC_CCCC;
        rst_i = 1'b1;
        en_i  = 1'b1;
        sel   = 2'b10;
        clk_run = 1'b1;
        tick();
        n_checks++;
        if (r_q !== '0 || sel_q !== 2'b00)
            $display("FAIL reset r_q=%h sel_q=%b expected 0/00", r_q, sel_q);
        else n_pass++;
        n_checks++;
        if (r !== 32'hCCCC_CCCC)
            $display("FAIL reset_comb r=%h expected %h", r, 32'hCCCC_CCCC);
        else n_pass++;
    endtask

    task automatic test_load_hold();
        rst_i = 1'b0;
        en_i  = 1'b1;
        sel   = 2'b01;
        tick();
        n_checks++;
        if (r_q !== 32'hBBBB_BBBB || sel_q !== 2'b01)
            $display("FAIL load r_q=%h sel_q=%b expected BBBBBBBB/01", r_q, sel_q);
        else n_pass++;
        en_i = 1'b0;
        sel  = 2'b00;
        tick();
        tick();
        n_checks++;
        if (r_q !== 32'hBBBB_BBBB || sel_q !== 2'b01)
            $display("FAIL hold r_q=%h sel_q=%b expected BBBBBBBB/01", r_q, sel_q);
        else n_pass++;
        n_checks++;
        if (r !== 32'hAAAA_AAAA)
            $display("FAIL hold_comb r=%h expected %h", r, 32'hAAAA_AAAA);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        en_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sel   = 2'(i % 3);
            rst_i = (i == 4);
            tick();
            n_checks++;
            if (r_q !== m_rq || sel_q !== m_selq)
                $display("FAIL reset_midstream cyc=%0d r_q=%h sel_q=%b expected %h/%b",
                         i, r_q, sel_q, m_rq, m_selq);
            else n_pass++;
            if (i == 4) begin
                n_checks++;
                if (r_q !== '0)
                    $display("FAIL reset_midstream_clear r_q=%h expected 0", r_q);
                else n_pass++;
            end
        end
        rst_i = 1'b0;
    endtask

    task automatic test_width_corner();
        a = 32'h8000_0000;
        b = 32'h0000_0000;
        c = 32'h7FFF_FFFF;
        en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            n_checks++;
            if (r !== ref_mux(a, b, c, sel))
                $display("FAIL width_corner_r sel=%0d r=%h expected %h", i, r, ref_mux(a, b, c, sel));
            else n_pass++;
            tick();
            n_checks++;
            if (r_q !== m_rq || sel_q !== m_selq)
                $display("FAIL width_corner_rq sel=%0d r_q=%h sel_q=%b expected %h/%b",
                         i, r_q, sel_q, m_rq, m_selq);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            a     = $urandom;
            b     = $urandom;
            c     = $urandom;
            sel   = 2'($urandom_range(0, 3));
            en_i  = ($urandom_range(0, 3) != 0);
            rst_i = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++;
            if (r !== ref_mux(a, b, c, sel))
                $display("FAIL random_r i=%0d r=%h expected %h", i, r, ref_mux(a, b, c, sel));
            else n_pass++;
            tick();
            n_checks++;
            if (r_q !== m_rq || sel_q !== m_selq)
                $display("FAIL random_rq i=%0d r_q=%h sel_q=%b expected %h/%b",
                         i, r_q, sel_q, m_rq, m_selq);
            else n_pass++;
        end
        rst_i = 1'b0;
    endtask

    initial begin
        m_rq   = '0;
        m_selq = 2'b00;
        test_comb_sweep();
        test_data_indep();
        test_reset();
        test_load_hold();
        test_reset_midstream();
        test_width_corner();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
